missile_pool: RTL and testbench
===============================

// Module: missile_pool
// PURPOSE
//  Manages a pool of NUM_MISSILES independent player missiles sharing one fire button.
//  Generalises the single-missile mover: launches each shot into the lowest free slot, moves all live
//  slots once per frame in fixed point, retires slots on per-slot collision or leaving the play area,
//  and enforces a frame-based fire cooldown. Sits between the player controller and drawing/collision logic.
// PARAMETERS
//  NUM_MISSILES     4     number of missile slots (1..16)
//  PIXEL_WIDTH      11    signed pixel coordinate width
//  FRAC_BITS        6     fixed-point fraction bits (1/64 pixel)
//  X_SPEED          0     per-frame X step, fixed-point units (signed)
//  Y_SPEED          -256  per-frame Y step, fixed-point units (signed)
//  X_OFFSET         15    launch X offset from ship top-left, pixels
//  Y_OFFSET         0     launch Y offset from ship top-left, pixels
//  COOLDOWN_FRAMES  8     frames after a launch during which shots are rejected (0 = none)
//  X_MIN/X_MAX      0/639 live X range, pixels, inclusive
//  Y_MIN/Y_MAX      0/479 live Y range, pixels, inclusive
// PORTS
//  clk             in   1                  system clock
//  reset           in   1                  synchronous, active-high reset
//  enable          in   1                  1 = run; 0 = freeze all state, ignore inputs
//  startOfFrame    in   1                  one-cycle pulse per frame
//  shooting_pulse  in   1                  one-cycle fire request
//  collision       in   NUM_MISSILES       per-slot hit, bit i retires slot i
//  spaceShip_X     in   PIXEL_WIDTH        ship top-left X
//  spaceShip_Y     in   PIXEL_WIDTH        ship top-left Y
//  topLeftX        out  NUM_MISSILES*PW    packed slot X, slot i at [i*PW +: PW], signed
//  topLeftY        out  NUM_MISSILES*PW    packed slot Y, same packing
//  missile_active  out  NUM_MISSILES       slot i live
//  shot_launched   out  1                  one-cycle pulse on the launch cycle
//  shot_rejected   out  1                  one-cycle pulse when a pending shot is dropped
//  pool_full       out  1                  combinational: &missile_active
// BEHAVIOUR
//  - Reset (has priority over enable): positions 0, missile_active 0, pending 0, cooldown 0, pulses 0.
//  - enable=0: every register holds; pulses forced 0; shooting_pulse/collision/startOfFrame ignored.
//  - Fire latch: shooting_pulse sets pending (max one queued shot). If it coincides with startOfFrame, the
//    current frame update uses the old pending and pending is set for the next frame (never lost).
//  - Frame update (startOfFrame=1, enable=1), all in the same clock edge:
//    * cooldown>0 -> cooldown-1.
//    * pending & cooldown==0 & free slot: lowest-index inactive slot i loads ((ship+OFFSET)<<FRAC_BITS),
//      becomes active, does not move this frame; cooldown<=COOLDOWN_FRAMES; shot_launched=1.
//    * pending & (cooldown!=0 | pool_full): shot discarded, shot_rejected=1.
//    * pending cleared unless re-set that cycle by shooting_pulse.
//    * every other active slot adds X_SPEED/Y_SPEED; if the new pixel position is outside
//      [X_MIN,X_MAX]x[Y_MIN,Y_MAX] the slot goes inactive in that same edge (position held).
//  - Collision: collision[i] clears missile_active[i] and zeroes its position on that edge, overriding
//    movement; a slot freed by collision on a frame edge is NOT reusable until the next frame.
//    collision on an inactive slot is ignored.
//  - Arithmetic: internal position signed PIXEL_WIDTH+FRAC_BITS+1 bits; pixel = arithmetic >>>FRAC_BITS
//    (floor toward -inf); bounds compare is signed. Launch sum sign-extended before shift.
//  - Outputs registered except pool_full; position visible one cycle after the frame edge.
// STRUCTURE
//  - missile_pkg: FRAC_BITS default, fixed-point type fp_pos_t, to_fp()/to_pix() functions, bounds defaults.
//  - Sub-module missile_slot (one per slot, generate loop): load/move/retire, position regs, bounds check.
//  - Top: fire latch, cooldown counter, lowest-free priority encoder, pulse generation.
// TESTING
//  - Ship (100,400), one pulse then frame -> slot0 active at (115,400); next 4 frames Y=396,392,388,384.
//  - 5 pulses spaced 10 frames, COOLDOWN=8 -> slots 0..3 fill, 5th gives shot_rejected, pool_full=1.
//  - Two pulses 3 frames apart, COOLDOWN=8 -> second rejected, only slot0 active.
//  - Slot0 reaches Y=1 with Y_SPEED=-256 -> next frame Y=-3 < Y_MIN, active clears, slot reusable.
//  - collision=4'b0010 with slots 0,1 live -> slot1 cleared on that edge, slot0 keeps moving; next shot uses slot1.
//  - shooting_pulse coincident with startOfFrame -> launch on the following frame; reset mid-flight clears all;
//    enable=0 for 3 frames -> positions unchanged.

Source files
------------

// File: rtl/missile_pkg.sv
// Shared defaults and fixed-point helpers for the player missile pool.
package missile_pkg;

  localparam int PIXEL_WIDTH_DEF = 11;
  localparam int FRAC_BITS_DEF   = 6;
  localparam int FP_WIDTH_DEF    = PIXEL_WIDTH_DEF + FRAC_BITS_DEF + 1;
  localparam int X_MIN_DEF       = 0;
  localparam int X_MAX_DEF       = 639;
  localparam int Y_MIN_DEF       = 0;
  localparam int Y_MAX_DEF       = 479;

  typedef logic signed [FP_WIDTH_DEF-1:0] fp_pos_t;

  function automatic fp_pos_t to_fp(input logic signed [PIXEL_WIDTH_DEF:0] pix);
    return fp_pos_t'(pix) <<< FRAC_BITS_DEF;
  endfunction

  function automatic logic signed [PIXEL_WIDTH_DEF-1:0] to_pix(input fp_pos_t fp);
    return PIXEL_WIDTH_DEF'(fp >>> FRAC_BITS_DEF);
  endfunction

endpackage

// File: rtl/missile_slot.sv
// One missile slot: launch load, per-frame fixed-point move, retire on hit or leaving the play area.
module missile_slot
  import missile_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int FRAC_BITS   = FRAC_BITS_DEF,
  parameter int X_SPEED     = 0,
  parameter int Y_SPEED     = -256,
  parameter int X_MIN       = X_MIN_DEF,
  parameter int X_MAX       = X_MAX_DEF,
  parameter int Y_MIN       = Y_MIN_DEF,
  parameter int Y_MAX       = Y_MAX_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 load,
  input  logic                                 move,
  input  logic                                 hit,
  input  logic signed [PIXEL_WIDTH+FRAC_BITS:0] load_x,
  input  logic signed [PIXEL_WIDTH+FRAC_BITS:0] load_y,
  output logic        [PIXEL_WIDTH-1:0]        pix_x,
  output logic        [PIXEL_WIDTH-1:0]        pix_y,
  output logic                                 active
);

  localparam int FP_W = PIXEL_WIDTH + FRAC_BITS + 1;
  localparam logic signed [FP_W-1:0] X_STEP = FP_W'(X_SPEED);
  localparam logic signed [FP_W-1:0] Y_STEP = FP_W'(Y_SPEED);
  localparam logic signed [FP_W-1:0] X_LO   = FP_W'(X_MIN);
  localparam logic signed [FP_W-1:0] X_HI   = FP_W'(X_MAX);
  localparam logic signed [FP_W-1:0] Y_LO   = FP_W'(Y_MIN);
  localparam logic signed [FP_W-1:0] Y_HI   = FP_W'(Y_MAX);

  logic signed [FP_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [FP_W-1:0] step_x, step_y, step_px, step_py;
  logic                   active_q, active_d, out_of_bounds;

  // Next position/liveness; a hit outranks everything, a retiring slot keeps its last position.
  always_comb begin
    step_x        = pos_x_q + X_STEP;
    step_y        = pos_y_q + Y_STEP;
    step_px       = step_x >>> FRAC_BITS;
    step_py       = step_y >>> FRAC_BITS;
    out_of_bounds = (step_px < X_LO) || (step_px > X_HI) || (step_py < Y_LO) || (step_py > Y_HI);
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    active_d      = active_q;
    if (enable && hit && active_q) begin
      pos_x_d  = '0;
      pos_y_d  = '0;
      active_d = 1'b0;
    end else if (enable && load) begin
      pos_x_d  = load_x;
      pos_y_d  = load_y;
      active_d = 1'b1;
    end else if (enable && move && active_q && !out_of_bounds) begin
      pos_x_d = step_x;
      pos_y_d = step_y;
    end else if (enable && move && active_q) begin
      active_d = 1'b0;
    end else begin
      active_d = active_q;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      active_q <= 1'b0;
    end else begin
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      active_q <= active_d;
    end
  end

  assign pix_x  = PIXEL_WIDTH'(pos_x_q >>> FRAC_BITS);
  assign pix_y  = PIXEL_WIDTH'(pos_y_q >>> FRAC_BITS);
  assign active = active_q;

endmodule

// File: rtl/missile_pool.sv
// Pool of player missiles sharing one fire button: fire latch, cooldown, lowest-free slot launch.
module missile_pool
  import missile_pkg::*;
#(
  parameter int NUM_MISSILES    = 4,
  parameter int PIXEL_WIDTH     = PIXEL_WIDTH_DEF,
  parameter int FRAC_BITS       = FRAC_BITS_DEF,
  parameter int X_SPEED         = 0,
  parameter int Y_SPEED         = -256,
  parameter int X_OFFSET        = 15,
  parameter int Y_OFFSET        = 0,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int X_MIN           = X_MIN_DEF,
  parameter int X_MAX           = X_MAX_DEF,
  parameter int Y_MIN           = Y_MIN_DEF,
  parameter int Y_MAX           = Y_MAX_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              startOfFrame,
  input  logic                              shooting_pulse,
  input  logic [NUM_MISSILES-1:0]           collision,
  input  logic [PIXEL_WIDTH-1:0]            spaceShip_X,
  input  logic [PIXEL_WIDTH-1:0]            spaceShip_Y,
  output logic [NUM_MISSILES*PIXEL_WIDTH-1:0] topLeftX,
  output logic [NUM_MISSILES*PIXEL_WIDTH-1:0] topLeftY,
  output logic [NUM_MISSILES-1:0]           missile_active,
  output logic                              shot_launched,
  output logic                              shot_rejected,
  output logic                              pool_full
);

  localparam int FP_W = PIXEL_WIDTH + FRAC_BITS + 1;
  localparam int CW   = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int IW   = (NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1;

  logic                   pending_q, pending_d;
  logic [CW-1:0]          cooldown_q, cooldown_d;
  logic                   shot_launched_q, shot_launched_d;
  logic                   shot_rejected_q, shot_rejected_d;
  logic [NUM_MISSILES-1:0] load_vec, active_vec;
  logic                   free_found;
  logic [IW-1:0]          free_idx;
  logic signed [FP_W-1:0] launch_x, launch_y;

  // Ship coordinates are sign-extended before the offset add so negative positions stay correct.
  assign launch_x = (FP_W'($signed(spaceShip_X)) + FP_W'(X_OFFSET)) <<< FRAC_BITS;
  assign launch_y = (FP_W'($signed(spaceShip_Y)) + FP_W'(Y_OFFSET)) <<< FRAC_BITS;

  // Lowest-index inactive slot; scanning downward lets the lowest index win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_MISSILES - 1; i >= 0; i--) begin
      free_found = free_found | ~active_vec[i];
      free_idx   = active_vec[i] ? free_idx : IW'(i);
    end
  end

  // Fire latch, cooldown and launch/reject decisions.
  always_comb begin
    pending_d       = pending_q;
    cooldown_d      = cooldown_q;
    shot_launched_d = 1'b0;
    shot_rejected_d = 1'b0;
    load_vec        = '0;
    if (enable && startOfFrame) begin
      cooldown_d = (cooldown_q != '0) ? cooldown_q - CW'(1) : cooldown_q;
      pending_d  = shooting_pulse;
      if (pending_q && (cooldown_q == '0) && free_found) begin
        load_vec[free_idx] = 1'b1;
        cooldown_d         = CW'(COOLDOWN_FRAMES);
        shot_launched_d    = 1'b1;
      end else if (pending_q) begin
        shot_rejected_d = 1'b1;
      end else begin
        shot_rejected_d = 1'b0;
      end
    end else if (enable) begin
      pending_d = pending_q | shooting_pulse;
    end else begin
      pending_d = pending_q;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q       <= 1'b0;
      cooldown_q      <= '0;
      shot_launched_q <= 1'b0;
      shot_rejected_q <= 1'b0;
    end else begin
      pending_q       <= pending_d;
      cooldown_q      <= cooldown_d;
      shot_launched_q <= shot_launched_d;
      shot_rejected_q <= shot_rejected_d;
    end
  end

  for (genvar g = 0; g < NUM_MISSILES; g++) begin : g_slot
    missile_slot #(
      .PIXEL_WIDTH(PIXEL_WIDTH), .FRAC_BITS(FRAC_BITS),
      .X_SPEED(X_SPEED), .Y_SPEED(Y_SPEED),
      .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
    ) u_slot (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .load   (load_vec[g]),
      .move   (startOfFrame),
      .hit    (collision[g]),
      .load_x (launch_x),
      .load_y (launch_y),
      .pix_x  (topLeftX[g*PIXEL_WIDTH +: PIXEL_WIDTH]),
      .pix_y  (topLeftY[g*PIXEL_WIDTH +: PIXEL_WIDTH]),
      .active (active_vec[g])
    );
  end

  assign missile_active = active_vec;
  assign pool_full      = &active_vec;
  assign shot_launched  = shot_launched_q;
  assign shot_rejected  = shot_rejected_q;

endmodule

// File: tb/tb_missile_pool.sv
// Scenario bench for missile_pool: a behavioural pool model feeds a scoreboard checked every cycle.
module tb_missile_pool;

  localparam int N  = 4;
  localparam int PW = 11;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b1;
  logic              startOfFrame = 1'b0;
  logic              shooting_pulse = 1'b0;
  logic [N-1:0]      collision = '0;
  logic [PW-1:0]     spaceShip_X = '0;
  logic [PW-1:0]     spaceShip_Y = '0;
  logic [N*PW-1:0]   topLeftX, topLeftY;
  logic [N-1:0]      missile_active;
  logic              shot_launched, shot_rejected, pool_full;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N-1:0]    act;
    logic [N*PW-1:0] x;
    logic [N*PW-1:0] y;
    logic            launched;
    logic            rejected;
  } exp_t;
  exp_t sb[$];

  int m_x[N], m_y[N], m_cd;
  bit m_act[N];
  bit m_pend, m_l, m_r;

  missile_pool dut (
    .clk(clk), .reset(reset), .enable(enable), .startOfFrame(startOfFrame),
    .shooting_pulse(shooting_pulse), .collision(collision),
    .spaceShip_X(spaceShip_X), .spaceShip_Y(spaceShip_Y),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .missile_active(missile_active),
    .shot_launched(shot_launched), .shot_rejected(shot_rejected), .pool_full(pool_full)
  );

  always #5 clk = ~clk;

  // Reference behaviour: X step 0, Y step -256 (4 px), offset (15,0), cooldown 8, 640x480 area.
  function automatic void model_step(bit rst, bit en, bit sof, bit shoot, logic [N-1:0] coll);
    int idx, cd_old, nx, ny, px, py, sx, sy;
    idx = -1; m_l = 1'b0; m_r = 1'b0;
    sx = $signed(spaceShip_X); sy = $signed(spaceShip_Y);
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_x[i] = 0; m_y[i] = 0; m_act[i] = 1'b0; end
      m_pend = 1'b0; m_cd = 0;
      return;
    end
    if (!en) return;
    if (sof) begin
      for (int i = N - 1; i >= 0; i--) if (!m_act[i]) idx = i;
      cd_old = m_cd;
      if (m_cd > 0) m_cd = m_cd - 1;
      if (m_pend && cd_old == 0 && idx >= 0) begin m_cd = 8; m_l = 1'b1; end
      else if (m_pend) begin m_r = 1'b1; idx = -1; end
      else idx = -1;
      m_pend = shoot;
    end else if (shoot) begin
      m_pend = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (coll[i] && m_act[i]) begin
        m_act[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
      end else if (i == idx) begin
        m_x[i] = (sx + 15) * 64; m_y[i] = sy * 64; m_act[i] = 1'b1;
      end else if (sof && m_act[i]) begin
        nx = m_x[i]; ny = m_y[i] - 256; px = nx >>> 6; py = ny >>> 6;
        if (px < 0 || px > 639 || py < 0 || py > 479) m_act[i] = 1'b0;
        else begin m_x[i] = nx; m_y[i] = ny; end
      end
    end
  endfunction

  // One clock: drive inputs, push the model's expectation, pop and compare after the edge.
  task automatic cyc(input bit sof, input bit shoot, input logic [N-1:0] coll);
    exp_t e, got;
    startOfFrame = sof; shooting_pulse = shoot; collision = coll;
    model_step(reset, enable, sof, shoot, coll);
    for (int i = 0; i < N; i++) begin
      e.act[i] = m_act[i];
      e.x[i*PW +: PW] = PW'(m_x[i] >>> 6);
      e.y[i*PW +: PW] = PW'(m_y[i] >>> 6);
    end
    e.launched = m_l; e.rejected = m_r;
    sb.push_back(e);
    @(posedge clk); #1;
    got = sb.pop_front();
    checks += 6;
    if (missile_active !== got.act) begin errors++; $display("FAIL active: got %b expected %b", missile_active, got.act); end
    if (topLeftX !== got.x) begin errors++; $display("FAIL pos_x: got %h expected %h", topLeftX, got.x); end
    if (topLeftY !== got.y) begin errors++; $display("FAIL pos_y: got %h expected %h", topLeftY, got.y); end
    if (shot_launched !== got.launched) begin errors++; $display("FAIL launched: got %b expected %b", shot_launched, got.launched); end
    if (shot_rejected !== got.rejected) begin errors++; $display("FAIL rejected: got %b expected %b", shot_rejected, got.rejected); end
    if (pool_full !== (&got.act)) begin errors++; $display("FAIL pool_full: got %b expected %b", pool_full, &got.act); end
    startOfFrame = 1'b0; shooting_pulse = 1'b0; collision = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(1'b0, 1'b0, '0); reset = 1'b0;
  endtask

  task automatic idle_frames(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, '0);
  endtask

  task automatic shoot_frame();
    cyc(1'b0, 1'b1, '0); cyc(1'b1, 1'b0, '0);
  endtask

  task automatic test_reset();
    shooting_pulse = 1'b1;
    do_reset();
    checks += 2;
    if (missile_active !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b expected 0000", missile_active); end
    if (topLeftX !== '0 || topLeftY !== '0) begin errors++; $display("FAIL reset_pos: got %h/%h expected 0", topLeftX, topLeftY); end
  endtask

  task automatic test_single();
    spaceShip_X = 11'd100; spaceShip_Y = 11'd400;
    do_reset(); shoot_frame();
    checks += 2;
    if (topLeftX[PW-1:0] !== 11'd115 || topLeftY[PW-1:0] !== 11'd400) begin
      errors++; $display("FAIL single_launch: got (%0d,%0d) expected (115,400)", topLeftX[PW-1:0], topLeftY[PW-1:0]);
    end
    if (shot_launched !== 1'b1) begin errors++; $display("FAIL single_pulse: got %b expected 1", shot_launched); end
    for (int k = 1; k <= 4; k++) begin
      idle_frames(1);
      checks++;
      if (topLeftY[PW-1:0] !== PW'(400 - 4 * k)) begin
        errors++; $display("FAIL single_move: got %0d expected %0d", topLeftY[PW-1:0], 400 - 4 * k);
      end
    end
  endtask

  task automatic test_pool_fill();
    spaceShip_X = 11'd200; spaceShip_Y = 11'd300;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      shoot_frame();
      if (k < 4) idle_frames(9);
    end
    checks++;
    if (shot_rejected !== 1'b1 || pool_full !== 1'b1 || missile_active !== 4'b1111) begin
      errors++; $display("FAIL pool_fill: got rej=%b full=%b act=%b expected 1 1 1111", shot_rejected, pool_full, missile_active);
    end
  endtask

  task automatic test_cooldown();
    spaceShip_X = 11'd100; spaceShip_Y = 11'd400;
    do_reset(); shoot_frame(); idle_frames(2); shoot_frame();
    checks++;
    if (shot_rejected !== 1'b1 || missile_active !== 4'b0001) begin
      errors++; $display("FAIL cooldown: got rej=%b act=%b expected 1 0001", shot_rejected, missile_active);
    end
  endtask

  task automatic test_bounds();
    spaceShip_X = 11'd50; spaceShip_Y = 11'd9;
    do_reset(); shoot_frame(); idle_frames(2);
    checks++;
    if (topLeftY[PW-1:0] !== 11'd1) begin errors++; $display("FAIL bounds_y1: got %0d expected 1", topLeftY[PW-1:0]); end
    idle_frames(1);
    checks++;
    if (missile_active[0] !== 1'b0 || topLeftY[PW-1:0] !== 11'd1) begin
      errors++; $display("FAIL bounds_exit: got act=%b y=%0d expected 0 1", missile_active[0], topLeftY[PW-1:0]);
    end
    idle_frames(6); shoot_frame();
    checks++;
    if (missile_active !== 4'b0001 || topLeftY[PW-1:0] !== 11'd9) begin
      errors++; $display("FAIL bounds_reuse: got act=%b y=%0d expected 0001 9", missile_active, topLeftY[PW-1:0]);
    end
  endtask

  task automatic test_collision();
    spaceShip_X = 11'd100; spaceShip_Y = 11'd400;
    do_reset(); shoot_frame(); idle_frames(9); shoot_frame();
    cyc(1'b1, 1'b0, 4'b0010);
    checks++;
    if (missile_active !== 4'b0001 || topLeftY[PW +: PW] !== 11'd0 || topLeftY[PW-1:0] !== 11'd356) begin
      errors++; $display("FAIL collision_hit: got act=%b y1=%0d y0=%0d expected 0001 0 356", missile_active, topLeftY[PW +: PW], topLeftY[PW-1:0]);
    end
    cyc(1'b0, 1'b0, 4'b1000);
    idle_frames(8); shoot_frame();
    checks++;
    if (missile_active !== 4'b0011) begin errors++; $display("FAIL collision_reuse: got %b expected 0011", missile_active); end
  endtask

  task automatic test_coincident();
    spaceShip_X = 11'd300; spaceShip_Y = 11'd200;
    do_reset(); cyc(1'b1, 1'b1, '0);
    checks++;
    if (shot_launched !== 1'b0) begin errors++; $display("FAIL coincident_early: got %b expected 0", shot_launched); end
    cyc(1'b1, 1'b0, '0);
    checks++;
    if (shot_launched !== 1'b1 || missile_active !== 4'b0001) begin
      errors++; $display("FAIL coincident_launch: got %b/%b expected 1/0001", shot_launched, missile_active);
    end
  endtask

  task automatic test_enable();
    spaceShip_X = 11'd100; spaceShip_Y = 11'd400;
    do_reset(); shoot_frame();
    enable = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 4'b0001);
    checks++;
    if (topLeftY[PW-1:0] !== 11'd400 || missile_active !== 4'b0001) begin
      errors++; $display("FAIL enable_hold: got y=%0d act=%b expected 400 0001", topLeftY[PW-1:0], missile_active);
    end
    enable = 1'b1; idle_frames(1);
    checks++;
    if (topLeftY[PW-1:0] !== 11'd396 || shot_launched !== 1'b0) begin
      errors++; $display("FAIL enable_resume: got y=%0d l=%b expected 396 0", topLeftY[PW-1:0], shot_launched);
    end
  endtask

  task automatic test_reset_mid();
    spaceShip_X = 11'd100; spaceShip_Y = 11'd400;
    do_reset(); shoot_frame(); idle_frames(9); shoot_frame(); idle_frames(2);
    enable = 1'b0; do_reset(); enable = 1'b1;
    checks++;
    if (missile_active !== 4'b0000 || topLeftY !== '0) begin
      errors++; $display("FAIL reset_mid: got act=%b y=%h expected 0", missile_active, topLeftY);
    end
    shoot_frame();
    checks++;
    if (missile_active !== 4'b0001) begin errors++; $display("FAIL reset_cooldown: got %b expected 0001", missile_active); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pool_fill();
    test_cooldown();
    test_bounds();
    test_collision();
    test_coincident();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
